// File: rtl/cache_nwsa_ctrl_if.sv
// CPU-side and memory-side bus of the N-way set-associative cache controller.
// The master modport is the environment (CPU plus memory); the slave modport is the cache.
interface cache_nwsa_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] addr_cpu;
   logic [DATA_W-1:0] data_cpu_in;
   logic [DATA_W-1:0] data_cpu_out;
   logic              rd_cpu;
   logic              wr_cpu;
   logic              stall_cpu;
   logic              done_cpu;
   logic [ADDR_W-1:0] addr_mem;
   logic [DATA_W-1:0] data_mem_in;
   logic [DATA_W-1:0] data_mem_out;
   logic              rd_mem;
   logic              wr_mem;
   logic              ready_mem;

   modport master (
      output addr_cpu, data_cpu_in, rd_cpu, wr_cpu, data_mem_in, ready_mem,
      input  data_cpu_out, stall_cpu, done_cpu, addr_mem, data_mem_out, rd_mem, wr_mem
   );

   modport slave (
      input  addr_cpu, data_cpu_in, rd_cpu, wr_cpu, data_mem_in, ready_mem,
      output data_cpu_out, stall_cpu, done_cpu, addr_mem, data_mem_out, rd_mem, wr_mem
   );
endinterface

// File: rtl/cache_nwsa_ctrl.sv
// Write-back, write-allocate N-way set-associative cache with tree pseudo-LRU replacement,
// dirty-victim write-back bursts and a registered, stall-based CPU handshake.
module cache_nwsa_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int WAYS   = 2,
   parameter int SETS   = 8,
   parameter int WORDS  = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   cache_nwsa_ctrl_if.slave  io_bus
);
   localparam int OFS_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - OFS_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

   // Line storage and bookkeeping
   logic [DATA_W-1:0] r_data  [WAYS][SETS][WORDS];
   logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
   logic [SETS-1:0]   r_valid [WAYS];
   logic [SETS-1:0]   r_dirty [WAYS];
   logic [2:0]        r_plru  [SETS];

   state_t            r_state;
   logic [TAG_W-1:0]  r_req_tag;
   logic [IDX_W-1:0]  r_req_idx;
   logic [OFS_W-1:0]  r_req_ofs;
   logic [DATA_W-1:0] r_req_wdata;
   logic              r_req_wr;
   logic [WAY_W-1:0]  r_way;
   logic [OFS_W-1:0]  r_beat;

   logic [DATA_W-1:0] r_data_cpu_out;
   logic              r_stall_cpu;
   logic              r_done_cpu;
   logic [ADDR_W-1:0] r_addr_mem;
   logic [DATA_W-1:0] r_data_mem_out;
   logic              r_rd_mem;
   logic              r_wr_mem;

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [OFS_W-1:0]  w_ofs;
   logic              w_req;
   logic              w_hit;
   logic [WAY_W-1:0]  w_hit_way;
   logic              w_has_inv;
   logic [WAY_W-1:0]  w_inv_way;
   logic [WAY_W-1:0]  w_victim;
   logic              w_victim_dirty;
   logic              w_last;
   logic [OFS_W-1:0]  w_beat_nxt;
   logic              w_fill_we;
   logic              w_tag_we;
   logic              w_cpu_we;
   logic [WAY_W-1:0]  w_cpu_way;
   logic [IDX_W-1:0]  w_cpu_idx;
   logic [OFS_W-1:0]  w_cpu_ofs;
   logic [DATA_W-1:0] w_cpu_wdata;

   // Tree bits: [0] root (1 = right half is LRU), [1] LRU of ways 0/1, [2] LRU of ways 2/3.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] p);
      int v;
      v = 0;
      if (WAYS == 2)      v = p[0] ? 1 : 0;
      else if (WAYS == 4) v = p[0] ? (p[2] ? 3 : 2) : (p[1] ? 1 : 0);
      return WAY_W'(v);
   endfunction

   function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] w);
      logic [2:0] n;
      int         wi;
      n  = p;
      wi = int'(w);
      if (WAYS == 2) begin
         n[0] = (wi == 0);
      end else if (WAYS == 4) begin
         n[0] = (wi < 2);
         if (wi < 2) n[1] = (wi == 0);
         else        n[2] = (wi == 2);
      end
      return n;
   endfunction

   assign {w_tag, w_idx, w_ofs} = io_bus.addr_cpu;
   assign w_req      = io_bus.rd_cpu | io_bus.wr_cpu;
   assign w_last     = (r_beat == LAST_BEAT);
   assign w_beat_nxt = r_beat + 1'b1;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_has_inv = 1'b0;
      w_inv_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w][w_idx]) begin
            w_has_inv = 1'b1;
            w_inv_way = WAY_W'(w);
         end
      end
   end

   assign w_victim       = w_has_inv ? w_inv_way : plru_victim(r_plru[w_idx]);
   assign w_victim_dirty = r_valid[w_victim][w_idx] & r_dirty[w_victim][w_idx];

   assign w_fill_we = !i_reset && (r_state == S_FILL) && io_bus.ready_mem;
   assign w_tag_we  = w_fill_we && w_last;

   always_comb begin
      w_cpu_we    = 1'b0;
      w_cpu_way   = w_hit_way;
      w_cpu_idx   = w_idx;
      w_cpu_ofs   = w_ofs;
      w_cpu_wdata = io_bus.data_cpu_in;
      if (!i_reset && (r_state == S_IDLE) && w_req && !io_bus.rd_cpu && w_hit) begin
         w_cpu_we = 1'b1;
      end else if (w_fill_we && w_last && r_req_wr) begin
         // Write-allocate merge; issued after the fill write so it wins on the same word.
         w_cpu_we    = 1'b1;
         w_cpu_way   = r_way;
         w_cpu_idx   = r_req_idx;
         w_cpu_ofs   = r_req_ofs;
         w_cpu_wdata = r_req_wdata;
      end
   end

   // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents count.
   always_ff @(posedge i_clock) begin
      if (w_fill_we) r_data[r_way][r_req_idx][r_beat]       <= io_bus.data_mem_in;
      if (w_cpu_we)  r_data[w_cpu_way][w_cpu_idx][w_cpu_ofs] <= w_cpu_wdata;
      if (w_tag_we)  r_tag[r_way][r_req_idx]                 <= r_req_tag;
   end

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         for (int w = 0; w < WAYS; w++) begin
            r_valid[w] <= '0;
            r_dirty[w] <= '0;
         end
         for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
         r_req_tag      <= '0;
         r_req_idx      <= '0;
         r_req_ofs      <= '0;
         r_req_wdata    <= '0;
         r_req_wr       <= 1'b0;
         r_way          <= '0;
         r_beat         <= '0;
         r_data_cpu_out <= '0;
         r_stall_cpu    <= 1'b0;
         r_done_cpu     <= 1'b0;
         r_addr_mem     <= '0;
         r_data_mem_out <= '0;
         r_rd_mem       <= 1'b0;
         r_wr_mem       <= 1'b0;
      end else begin
         r_done_cpu <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req && w_hit) begin
                  r_state      <= S_DONE;
                  r_done_cpu   <= 1'b1;
                  r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                  if (io_bus.rd_cpu) r_data_cpu_out <= r_data[w_hit_way][w_idx][w_ofs];
                  else               r_dirty[w_hit_way][w_idx] <= 1'b1;
               end else if (w_req) begin
                  r_req_tag   <= w_tag;
                  r_req_idx   <= w_idx;
                  r_req_ofs   <= w_ofs;
                  r_req_wdata <= io_bus.data_cpu_in;
                  r_req_wr    <= !io_bus.rd_cpu;
                  r_way       <= w_victim;
                  r_beat      <= '0;
                  r_stall_cpu <= 1'b1;
                  if (w_victim_dirty) begin
                     r_state        <= S_WB;
                     r_wr_mem       <= 1'b1;
                     r_addr_mem     <= {r_tag[w_victim][w_idx], w_idx, {OFS_W{1'b0}}};
                     r_data_mem_out <= r_data[w_victim][w_idx][0];
                  end else begin
                     r_state    <= S_FILL;
                     r_rd_mem   <= 1'b1;
                     r_addr_mem <= {w_tag, w_idx, {OFS_W{1'b0}}};
                  end
               end
            end
            S_WB: begin
               if (io_bus.ready_mem) begin
                  if (w_last) begin
                     r_state        <= S_FILL;
                     r_beat         <= '0;
                     r_wr_mem       <= 1'b0;
                     r_data_mem_out <= '0;
                     r_rd_mem       <= 1'b1;
                     r_addr_mem     <= {r_req_tag, r_req_idx, {OFS_W{1'b0}}};
                  end else begin
                     r_beat         <= w_beat_nxt;
                     r_addr_mem     <= {r_tag[r_way][r_req_idx], r_req_idx, w_beat_nxt};
                     r_data_mem_out <= r_data[r_way][r_req_idx][w_beat_nxt];
                  end
               end
            end
            S_FILL: begin
               if (io_bus.ready_mem) begin
                  if (!r_req_wr && (r_beat == r_req_ofs)) r_data_cpu_out <= io_bus.data_mem_in;
                  if (w_last) begin
                     r_state                   <= S_DONE;
                     r_beat                    <= '0;
                     r_rd_mem                  <= 1'b0;
                     r_addr_mem                <= '0;
                     r_valid[r_way][r_req_idx] <= 1'b1;
                     r_dirty[r_way][r_req_idx] <= r_req_wr;
                     r_plru[r_req_idx]         <= plru_touch(r_plru[r_req_idx], r_way);
                     r_stall_cpu               <= 1'b0;
                     r_done_cpu                <= 1'b1;
                  end else begin
                     r_beat     <= w_beat_nxt;
                     r_addr_mem <= {r_req_tag, r_req_idx, w_beat_nxt};
                  end
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.data_cpu_out = r_data_cpu_out;
   assign io_bus.stall_cpu    = r_stall_cpu;
   assign io_bus.done_cpu     = r_done_cpu;
   assign io_bus.addr_mem     = r_addr_mem;
   assign io_bus.data_mem_out = r_data_mem_out;
   assign io_bus.rd_mem       = r_rd_mem;
   assign io_bus.wr_mem       = r_wr_mem;
endmodule

// File: tb/tb_cache_nwsa_ctrl.sv
// Scoreboard bench for cache_nwsa_ctrl: reference CPU view, memory model with beat log and stall injection.
module tb_cache_nwsa_ctrl;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_nwsa_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   cache_nwsa_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(2), .SETS(8), .WORDS(4)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   logic [DATA_W-1:0] mem     [512];
   logic [DATA_W-1:0] ref_mem [512];
   logic [DATA_W-1:0] exp_q   [$];
   beat_t             log_q   [$];
   int n_checks;
   int n_fail;
   int viol;
   int hold_target;
   int hold_served;
   int hold_cnt;

   function automatic logic [DATA_W-1:0] init_val(input int a);
      case (a)
         'h134:   return 8'h11;
         'h135:   return 8'h22;
         'h136:   return 8'h33;
         'h137:   return 8'h44;
         default: return DATA_W'(a * 7 + 3);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Memory: beats accepted at the clock edge are logged; write beats update the backing store.
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (!rst && bus.ready_mem && bus.wr_mem) begin
            mem[bus.addr_mem] = bus.data_mem_out;
            log_q.push_back({1'b1, bus.addr_mem, bus.data_mem_out});
         end else if (!rst && bus.ready_mem && bus.rd_mem) begin
            log_q.push_back({1'b0, bus.addr_mem, bus.data_mem_in});
         end
      end
   end

   // Memory drive on the falling edge, with a one-shot 5-cycle ready hold and protocol monitor.
   initial begin
      bus.ready_mem   = 1'b0;
      bus.data_mem_in = '0;
      hold_served     = -1;
      hold_cnt        = 0;
      viol            = 0;
      forever begin
         @(negedge clk);
         if (bus.rd_mem && bus.wr_mem) viol++;
         if (!bus.rd_mem && !bus.wr_mem && (bus.addr_mem != '0)) viol++;
         if ((hold_target >= 0) && (hold_target != hold_served) && (log_q.size() == hold_target)) begin
            hold_cnt    = 5;
            hold_served = hold_target;
         end
         if (hold_cnt > 0) begin
            bus.ready_mem = 1'b0;
            hold_cnt--;
         end else begin
            bus.ready_mem = bus.rd_mem | bus.wr_mem;
         end
         bus.data_mem_in = bus.rd_mem ? mem[bus.addr_mem] : '0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cpu_access(input string tag, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, output int lat, output int n_stall);
      int cyc;
      logic [DATA_W-1:0] e;
      @(negedge clk);
      if (rd)      exp_q.push_back(ref_mem[a]);
      else if (wr) ref_mem[a] = d;
      bus.addr_cpu    = a;
      bus.data_cpu_in = d;
      bus.rd_cpu      = rd;
      bus.wr_cpu      = wr;
      cyc     = 0;
      n_stall = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (bus.stall_cpu) n_stall++;
      end while (!bus.done_cpu && cyc < 200);
      lat        = cyc;
      bus.rd_cpu = 1'b0;
      bus.wr_cpu = 1'b0;
      if (!bus.done_cpu) begin
         check({tag, "_timeout"}, 32'(cyc), 32'(0));
         if (rd) void'(exp_q.pop_front());
      end else begin
         check({tag, "_stall_at_done"}, 32'(bus.stall_cpu), 32'(0));
         if (rd) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, 32'(bus.data_cpu_out), 32'(e));
         end
      end
   endtask

   task automatic check_beats(input string tag, input int base, input beat_t exp[$]);
      int n;
      n = log_q.size() - base;
      check({tag, "_nbeats"}, 32'(n), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < n; i++)
         check($sformatf("%s_beat%0d", tag, i), 32'(log_q[base + i]), 32'(exp[i]));
   endtask

   function automatic void add_line(inout beat_t q[$], input logic wr, input int line, input logic [DATA_W-1:0] d[4]);
      for (int i = 0; i < 4; i++) q.push_back({wr, ADDR_W'(line + i), d[i]});
   endfunction

   initial begin
      int lat, ns, base, cyc;
      beat_t ex[$];
      logic [DATA_W-1:0] d4[4];

      n_checks        = 0;
      n_fail          = 0;
      hold_target     = -1;
      rst             = 1'b1;
      bus.addr_cpu    = '0;
      bus.data_cpu_in = '0;
      bus.rd_cpu      = 1'b0;
      bus.wr_cpu      = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_done",     32'(bus.done_cpu),     32'(0));
      check("rst_stall",    32'(bus.stall_cpu),    32'(0));
      check("rst_rd_mem",   32'(bus.rd_mem),       32'(0));
      check("rst_wr_mem",   32'(bus.wr_mem),       32'(0));
      check("rst_addr_mem", 32'(bus.addr_mem),     32'(0));
      check("rst_rdata",    32'(bus.data_cpu_out), 32'(0));
      check("rst_wdata",    32'(bus.data_mem_out), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];

      // Cold read miss: 4-beat fill of the line at 0x134.
      base = log_q.size();
      cpu_access("cold_rd", 1'b1, 1'b0, 9'h135, 8'h00, lat, ns);
      check("cold_rd_lat", 32'(lat), 32'(5));
      check("cold_rd_stall", 32'(ns), 32'(4));
      ex.delete();
      d4 = '{8'h11, 8'h22, 8'h33, 8'h44};
      add_line(ex, 1'b0, 'h134, d4);
      check_beats("cold_rd", base, ex);

      // Hits: latency 1, no stall, no memory traffic.
      base = log_q.size();
      cpu_access("hit_rd", 1'b1, 1'b0, 9'h137, 8'h00, lat, ns);
      check("hit_rd_lat", 32'(lat), 32'(1));
      check("hit_rd_stall", 32'(ns), 32'(0));
      cpu_access("hit_wr", 1'b0, 1'b1, 9'h135, 8'h35, lat, ns);
      check("hit_wr_lat", 32'(lat), 32'(1));
      cpu_access("hit_rdback", 1'b1, 1'b0, 9'h135, 8'h00, lat, ns);
      check("hit_rdback_stall", 32'(ns), 32'(0));
      cpu_access("rd_prio", 1'b1, 1'b1, 9'h137, 8'hAA, lat, ns);
      check("rd_prio_lat", 32'(lat), 32'(1));
      cpu_access("rd_prio_after", 1'b1, 1'b0, 9'h137, 8'h00, lat, ns);
      ex.delete();
      check_beats("hits", base, ex);

      // Second tag in set 5 fills the invalid way 1.
      base = log_q.size();
      cpu_access("fill_w1", 1'b1, 1'b0, 9'h194, 8'h00, lat, ns);
      check("fill_w1_lat", 32'(lat), 32'(5));
      ex.delete();
      d4 = '{init_val('h194), init_val('h195), init_val('h196), init_val('h197)};
      add_line(ex, 1'b0, 'h194, d4);
      check_beats("fill_w1", base, ex);

      // Third tag in set 5: LRU way 0 is dirty, written back before the fill.
      base = log_q.size();
      cpu_access("evict", 1'b1, 1'b0, 9'h0D6, 8'h00, lat, ns);
      check("evict_lat", 32'(lat), 32'(9));
      check("evict_stall", 32'(ns), 32'(8));
      ex.delete();
      d4 = '{8'h11, 8'h35, 8'h33, 8'h44};
      add_line(ex, 1'b1, 'h134, d4);
      d4 = '{init_val('hD4), init_val('hD5), init_val('hD6), init_val('hD7)};
      add_line(ex, 1'b0, 'hD4, d4);
      check_beats("evict", base, ex);

      // ready_mem held low 5 cycles after the second fill beat.
      base        = log_q.size();
      hold_target = base + 2;
      cpu_access("hold", 1'b1, 1'b0, 9'h069, 8'h00, lat, ns);
      check("hold_lat", 32'(lat), 32'(10));
      check("hold_stall", 32'(ns), 32'(9));
      ex.delete();
      d4 = '{init_val('h68), init_val('h69), init_val('h6A), init_val('h6B)};
      add_line(ex, 1'b0, 'h68, d4);
      check_beats("hold", base, ex);

      // Make set 2 full with way 0 dirty, then reset in the middle of its write-back.
      cpu_access("s2_wr", 1'b0, 1'b1, 9'h069, 8'h5A, lat, ns);
      check("s2_wr_lat", 32'(lat), 32'(1));
      cpu_access("s2_fill", 1'b1, 1'b0, 9'h0A8, 8'h00, lat, ns);
      check("s2_fill_lat", 32'(lat), 32'(5));
      @(negedge clk);
      base         = log_q.size();
      bus.addr_cpu = 9'h0E8;
      bus.rd_cpu   = 1'b1;
      cyc          = 0;
      while (log_q.size() < base + 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("wb_at_beat2", 32'(bus.wr_mem), 32'(1));
      rst        = 1'b1;
      bus.rd_cpu = 1'b0;
      @(negedge clk);
      check("rst_wb_wr_mem", 32'(bus.wr_mem), 32'(0));
      check("rst_wb_rd_mem", 32'(bus.rd_mem), 32'(0));
      check("rst_wb_stall", 32'(bus.stall_cpu), 32'(0));
      check("rst_wb_addr", 32'(bus.addr_mem), 32'(0));
      rst = 1'b0;
      ex.delete();
      ex.push_back({1'b1, 9'h068, init_val('h68)});
      ex.push_back({1'b1, 9'h069, 8'h5A});
      check_beats("partial_wb", base, ex);
      exp_q.delete();
      for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];

      // After reset the cache is empty: 0x135 misses and returns the written-back value.
      cpu_access("post_rst", 1'b1, 1'b0, 9'h135, 8'h00, lat, ns);
      check("post_rst_lat", 32'(lat), 32'(5));
      check("post_rst_stall", 32'(ns), 32'(4));

      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      check("protocol_viol", 32'(viol), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
